// File: rtl/scfifo_ver.sv
// scfifo_ver: single-clock FIFO, any depth >= 2, with normal or show-ahead read mode.
// Latency: flags/usedw follow the request edge by one cycle; normal-mode q 1 cycle after rdreq,
//   show-ahead q shows the head word as soon as empty drops.
// Backpressure: with checking on, wrreq is ignored while full and rdreq is ignored while empty.
//
// Ports:
//   clk          single clock, rising edge
//   reset_n      synchronous reset, active-low (wins over sclr)
//   sclr         synchronous clear, active-high
//   data/wrreq   write data and write request
//   rdreq        read request (normal) / pop acknowledge (show-ahead)
//   q            read data
//   empty, full  count == 0 / count == lpm_numwords
//   almost_full  count >= almost_full_value   (only with SCFIFO_ALMOST_FLAGS_EN, else 0)
//   almost_empty count <  almost_empty_value  (only with SCFIFO_ALMOST_FLAGS_EN, else 1)
//   usedw        low lpm_widthu bits of count (reads 0 when a power-of-two FIFO is full)
//
// Build option: define SCFIFO_ALMOST_FLAGS_EN to build the almost_full/almost_empty comparators.

module scfifo_ver #(
  parameter int    lpm_width          = 8,
  parameter int    lpm_numwords       = 16,
  parameter int    lpm_widthu         = 4,
  parameter string lpm_showahead      = "OFF",
  parameter string overflow_checking  = "ON",
  parameter string underflow_checking = "ON",
  parameter int    almost_full_value  = 12,
  parameter int    almost_empty_value = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  sclr,
  input  logic [lpm_width-1:0]  data,
  input  logic                  wrreq,
  input  logic                  rdreq,
  output logic [lpm_width-1:0]  q,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [lpm_widthu-1:0] usedw
);

  localparam int CW = lpm_widthu + 1;

  localparam logic [CW-1:0]         CNT_FULL   = CW'(lpm_numwords);
  localparam logic [lpm_widthu-1:0] PTR_LAST   = lpm_widthu'(lpm_numwords - 1);
  localparam bit                    SHOW_AHEAD = (lpm_showahead == "ON");
  localparam bit                    OVF_OFF    = (overflow_checking == "OFF");
  localparam bit                    UDF_OFF    = (underflow_checking == "OFF");

  logic [lpm_width-1:0]  mem [lpm_numwords];
  logic [lpm_widthu-1:0] wr_ptr;
  logic [lpm_widthu-1:0] rd_ptr;
  logic [CW-1:0]         count;

  logic clr;
  logic wr_ena;
  logic rd_ena;
  logic wr_go;
  logic rd_go;

  // Pointers wrap explicitly at lpm_numwords-1 so non-power-of-two depths work.
  function automatic logic [lpm_widthu-1:0] ptr_inc(input logic [lpm_widthu-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign clr    = ~reset_n | sclr;
  assign wr_ena = wrreq & (~full  | OVF_OFF);
  assign rd_ena = rdreq & (~empty | UDF_OFF);
  // Requests arriving in a reset/clear cycle are dropped, memory included.
  assign wr_go  = wr_ena & ~clr;
  assign rd_go  = rd_ena & ~clr;

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ena) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_ena) rd_ptr <= ptr_inc(rd_ptr);
      // Count saturates so an unchecked overflow/underflow can never push it
      // outside 0..lpm_numwords; the stored data is then undefined anyway.
      if (wr_ena && !rd_ena && count != CNT_FULL) begin
        count <= count + 1'b1;
      end else if (rd_ena && !wr_ena && count != '0) begin
        count <= count - 1'b1;
      end
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (wr_go) mem[wr_ptr] <= data;
  end

  generate
    if (SHOW_AHEAD) begin : g_show_ahead
      // Head word is presented directly; rdreq only pops it.
      assign q = mem[rd_ptr];
    end else begin : g_normal
      logic [lpm_width-1:0] q_reg;

      always_ff @(posedge clk) begin
        if (clr) begin
          q_reg <= '0;
        end else if (rd_go) begin
          q_reg <= mem[rd_ptr];
        end
      end

      assign q = q_reg;
    end
  endgenerate

  // All status outputs decode the count register only, never the requests.
  assign empty = (count == '0);
  assign full  = (count == CNT_FULL);
  assign usedw = count[lpm_widthu-1:0];

`ifdef SCFIFO_ALMOST_FLAGS_EN
  assign almost_full  = (count >= CW'(almost_full_value));
  assign almost_empty = (count <  CW'(almost_empty_value));
`else
  assign almost_full  = 1'b0;
  assign almost_empty = 1'b1;
`endif

endmodule

// File: tb/tb_scfifo_ver.sv
// tb_scfifo_ver: three scfifo_ver instances (N=16 normal, N=12 normal, N=12 show-ahead)
// driven with directed sequences then random traffic; a queue-based model predicts every
// output each cycle, and literal expectations pin the model on the directed sequences.

module tb_scfifo_ver;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       sclr;
  logic [7:0] data   [3];
  logic       wrreq  [3];
  logic       rdreq  [3];
  logic [7:0] q      [3];
  logic       empty  [3];
  logic       full   [3];
  logic       af     [3];
  logic       ae     [3];
  logic [3:0] usedw  [3];

  int checks   = 0;
  int failures = 0;
  bit cmp_on   = 1'b0;

`ifdef SCFIFO_ALMOST_FLAGS_EN
  localparam bit FLAGS_ON = 1'b1;
`else
  localparam bit FLAGS_ON = 1'b0;
`endif

  // Model: contents as a queue, plus the normal-mode output register.
  logic [7:0] mq    [3][$];
  logic [7:0] mqreg [3];

  scfifo_ver #(.lpm_numwords(16), .lpm_widthu(4)) u_n16 (
    .clk(clk), .reset_n(reset_n), .sclr(sclr), .data(data[0]), .wrreq(wrreq[0]),
    .rdreq(rdreq[0]), .q(q[0]), .empty(empty[0]), .full(full[0]),
    .almost_full(af[0]), .almost_empty(ae[0]), .usedw(usedw[0]));

  scfifo_ver #(.lpm_numwords(12), .lpm_widthu(4), .almost_full_value(12),
               .almost_empty_value(4)) u_n12 (
    .clk(clk), .reset_n(reset_n), .sclr(sclr), .data(data[1]), .wrreq(wrreq[1]),
    .rdreq(rdreq[1]), .q(q[1]), .empty(empty[1]), .full(full[1]),
    .almost_full(af[1]), .almost_empty(ae[1]), .usedw(usedw[1]));

  scfifo_ver #(.lpm_numwords(12), .lpm_widthu(4), .lpm_showahead("ON"),
               .almost_full_value(10), .almost_empty_value(3)) u_sa (
    .clk(clk), .reset_n(reset_n), .sclr(sclr), .data(data[2]), .wrreq(wrreq[2]),
    .rdreq(rdreq[2]), .q(q[2]), .empty(empty[2]), .full(full[2]),
    .almost_full(af[2]), .almost_empty(ae[2]), .usedw(usedw[2]));

  function automatic int nw(input int i);
    return (i == 0) ? 16 : 12;
  endfunction
  function automatic int af_thr(input int i);
    return (i == 2) ? 10 : 12;
  endfunction
  function automatic int ae_thr(input int i);
    return (i == 2) ? 3 : 4;
  endfunction
  function automatic bit is_sa(input int i);
    return (i == 2);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    for (int i = 0; i < 3; i++) begin
      wrreq[i] = 1'b0;
      rdreq[i] = 1'b0;
    end
  endtask

  // Compare the outputs left by the last edge, then advance the model with the
  // inputs the DUT is about to sample on the next edge.
  initial begin
    int         c;
    logic [7:0] hd;
    forever begin
      @(negedge clk);
      if (cmp_on) begin
        for (int i = 0; i < 3; i++) begin
          c = mq[i].size();
          chk($sformatf("empty[%0d]", i), empty[i], c == 0);
          chk($sformatf("full[%0d]", i), full[i], c == nw(i));
          chk($sformatf("usedw[%0d]", i), usedw[i], c % 16);
          chk($sformatf("almost_full[%0d]", i), af[i], FLAGS_ON && (c >= af_thr(i)));
          chk($sformatf("almost_empty[%0d]", i), ae[i], !FLAGS_ON || (c < ae_thr(i)));
          if (!is_sa(i)) chk($sformatf("q[%0d]", i), q[i], mqreg[i]);
          else if (c > 0) chk($sformatf("q_sa[%0d]", i), q[i], mq[i][0]);
        end
      end
      for (int i = 0; i < 3; i++) begin
        if (!reset_n || sclr) begin
          mq[i].delete();
          mqreg[i] = 8'h00;
        end else begin
          c = mq[i].size();
          if (rdreq[i] && c > 0) begin
            hd = mq[i].pop_front();
            if (!is_sa(i)) mqreg[i] = hd;
          end
          if (wrreq[i] && c < nw(i)) mq[i].push_back(data[i]);
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    sclr    = 1'b0;
    for (int i = 0; i < 3; i++) data[i] = 8'h00;
    idle();
    repeat (2) tick();
    cmp_on = 1'b1;

    // Reset values
    for (int i = 0; i < 3; i++) begin
      chk("rst_empty", empty[i], 1);
      chk("rst_full", full[i], 0);
      chk("rst_usedw", usedw[i], 0);
      chk("rst_af", af[i], 0);
      chk("rst_ae", ae[i], 1);
    end
    chk("rst_q0", q[0], 0);
    chk("rst_q1", q[1], 0);
    reset_n = 1'b1;

    // N=16: fill with 0x01..0x10, watching the threshold crossings
    for (int k = 1; k <= 16; k++) begin
      wrreq[0] = 1'b1;
      data[0]  = 8'(k);
      tick();
      if (k == 3)  chk("ae_at_3", ae[0], 1);
      if (k == 4)  chk("ae_at_4", ae[0], !FLAGS_ON);
      if (k == 11) chk("af_at_11", af[0], 0);
      if (k == 12) chk("af_at_12", af[0], FLAGS_ON);
    end
    wrreq[0] = 1'b0;
    chk("n16_full", full[0], 1);
    chk("n16_usedw_full", usedw[0], 0);
    for (int k = 1; k <= 16; k++) begin
      rdreq[0] = 1'b1;
      tick();
      chk("n16_rd_order", q[0], k);
    end
    rdreq[0] = 1'b0;
    chk("n16_empty_after", empty[0], 1);

    // N=12: fill, then simultaneous read+write while full
    for (int k = 0; k < 12; k++) begin
      wrreq[1] = 1'b1;
      data[1]  = 8'h20 + 8'(k);
      tick();
    end
    chk("n12_full", full[1], 1);
    chk("n12_usedw_full", usedw[1], 12);
    data[1]  = 8'hEE;
    rdreq[1] = 1'b1;
    tick();
    wrreq[1] = 1'b0;
    chk("n12_rw_q", q[1], 8'h20);
    chk("n12_rw_usedw", usedw[1], 11);
    chk("n12_rw_full", full[1], 0);
    repeat (11) tick();
    rdreq[1] = 1'b0;
    chk("n12_last_word", q[1], 8'h2B);
    chk("n12_drained", empty[1], 1);

    // N=12: 30-word overlapped stream across the pointer wrap
    for (int k = 0; k < 30; k++) begin
      wrreq[1] = 1'b1;
      data[1]  = 8'h60 + 8'(k);
      rdreq[1] = (k >= 3);
      tick();
    end
    wrreq[1] = 1'b0;
    repeat (3) tick();
    rdreq[1] = 1'b0;
    chk("n12_stream_last", q[1], 8'h60 + 8'd29);
    chk("n12_stream_empty", empty[1], 1);

    // Show-ahead: written word visible the next cycle with no rdreq
    wrreq[2] = 1'b1;
    data[2]  = 8'hA5;
    tick();
    wrreq[2] = 1'b0;
    chk("sa_q", q[2], 8'hA5);
    chk("sa_empty", empty[2], 0);
    tick();
    chk("sa_q_held", q[2], 8'hA5);
    rdreq[2] = 1'b1;
    tick();
    rdreq[2] = 1'b0;
    chk("sa_popped", empty[2], 1);

    // sclr with 7 words stored, and a write during the clear is dropped
    for (int k = 0; k < 7; k++) begin
      wrreq[0] = 1'b1;
      data[0]  = 8'h40 + 8'(k);
      tick();
    end
    chk("pre_sclr_usedw", usedw[0], 7);
    sclr    = 1'b1;
    data[0] = 8'h77;
    tick();
    sclr     = 1'b0;
    wrreq[0] = 1'b0;
    chk("sclr_empty", empty[0], 1);
    chk("sclr_usedw", usedw[0], 0);
    chk("sclr_q", q[0], 0);

    // reset_n low during a write: the write is discarded
    reset_n  = 1'b0;
    wrreq[0] = 1'b1;
    data[0]  = 8'h99;
    tick();
    reset_n  = 1'b1;
    wrreq[0] = 1'b0;
    chk("rst_wr_empty", empty[0], 1);
    tick();
    chk("rst_wr_usedw", usedw[0], 0);

    // Random traffic with varying fill pressure and rare clears
    for (int seg = 0; seg < 15; seg++) begin
      int wp;
      int rp;
      wp = $urandom_range(90, 15);
      rp = $urandom_range(90, 15);
      repeat (200) begin
        for (int i = 0; i < 3; i++) begin
          wrreq[i] = ($urandom % 100) < wp;
          rdreq[i] = ($urandom % 100) < rp;
          data[i]  = 8'($urandom);
        end
        sclr = ($urandom % 300) == 0;
        tick();
      end
    end
    sclr = 1'b0;
    idle();
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
